// File: rtl/flash_read_responder.sv
// flash_read_responder
// Serves one read request from the shared-access arbiter. It latches the
// element address, issues a single word read to the memory slave, picks the
// addressed M-bit lane out of the returned W-bit word, and pulses finished.
//
// Optional feature: define RESP_TIMEOUT_EN to abandon a read that has spent
// TIMEOUT_CYCLES cycles in ISSUE/WAIT_DATA. An abandoned read returns zero
// data and raises timeout_error together with finished. Without the macro the
// responder waits indefinitely and timeout_error is tied low.
module flash_read_responder #(
  parameter int N              = 32,
  parameter int M              = 8,
  parameter int W              = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic         sm_clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] arguments,
  output logic         finished,
  output logic [M-1:0] received_data,
  output logic         busy,
  output logic [N-1:0] mem_address,
  output logic         mem_read,
  input  logic         mem_waitrequest,
  input  logic [W-1:0] mem_readdata,
  input  logic         mem_readdatavalid,
  output logic         timeout_error
);

  // Number of M-bit lanes in one memory word and the width of a lane index.
  localparam int LANES     = W / M;
  localparam int LANE_BITS = $clog2(LANES);
  localparam int LANE_W    = (LANE_BITS > 0) ? LANE_BITS : 1;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_DATA,
    SELECT,
    DONE
  } state_t;

  state_t         state_reg;
  state_t         state_next;
  logic [N-1:0]   addr_reg;
  logic [W-1:0]   data_reg;
  logic [M-1:0]   received_data_reg;
  logic           timeout_now;
  logic           timeout_take;
  logic [LANE_W-1:0] lane_idx;
  logic [M-1:0]   lane_word [LANES];

  // Split the captured word into its lanes; lane 0 is the least significant.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign lane_word[gi] = data_reg[gi*M +: M];
  end

  // Element address -> lane within the word and word address for the slave.
  assign lane_idx      = LANE_W'(addr_reg % N'(LANES));
  assign mem_address   = addr_reg >> LANE_BITS;
  assign received_data = received_data_reg;

`ifdef RESP_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_reg;
  logic             timeout_reg;

  // The count reaches TIMEOUT_CYCLES on the edge where this is true.
  assign timeout_now   = (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
  assign timeout_error = (state_reg == DONE) && timeout_reg;

  // Cycle counter for the memory phase plus a flag remembering an abandoned read.
  always_ff @(posedge sm_clk) begin
    if (reset) begin
      cnt_reg     <= '0;
      timeout_reg <= 1'b0;
    end else begin
      if (state_reg == IDLE) begin
        cnt_reg <= '0;
      end else if (state_reg == ISSUE || state_reg == WAIT_DATA) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
      if (state_reg == IDLE && start) begin
        timeout_reg <= 1'b0;
      end else if (timeout_take) begin
        timeout_reg <= 1'b1;
      end
    end
  end
`else
  assign timeout_now   = 1'b0;
  assign timeout_error = 1'b0;
`endif

  // State register; reset wins over any request in the same cycle.
  always_ff @(posedge sm_clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Datapath: latch the request, capture the word, and load the selected lane.
  always_ff @(posedge sm_clk) begin
    if (reset) begin
      addr_reg          <= '0;
      data_reg          <= '0;
      received_data_reg <= '0;
    end else begin
      if (state_reg == IDLE && start) begin
        addr_reg <= arguments;
      end
      if (state_reg == WAIT_DATA && mem_readdatavalid) begin
        data_reg <= mem_readdata;
      end
      if (state_reg == SELECT) begin
        received_data_reg <= lane_word[lane_idx];
      end else if (timeout_take) begin
        received_data_reg <= '0;
      end
    end
  end

  // Next-state logic and state-decoded outputs. A completed handshake or data
  // beat takes precedence over a timeout landing in the same cycle.
  always_comb begin
    state_next   = state_reg;
    timeout_take = 1'b0;
    busy         = (state_reg != IDLE);
    mem_read     = (state_reg == ISSUE);
    finished     = (state_reg == DONE);
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (!mem_waitrequest) begin
          state_next = WAIT_DATA;
        end else if (timeout_now) begin
          state_next   = DONE;
          timeout_take = 1'b1;
        end
      end
      WAIT_DATA: begin
        if (mem_readdatavalid) begin
          state_next = SELECT;
        end else if (timeout_now) begin
          state_next   = DONE;
          timeout_take = 1'b1;
        end
      end
      SELECT: begin
        state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_flash_read_responder.sv
// Testbench for flash_read_responder: randomized transactions against a slave
// model with random stall and data latency, checked against a reference that
// computes word address, lane and completion cycle arithmetically.
module tb_flash_read_responder;

  localparam int N  = 32;
  localparam int M  = 8;
  localparam int W  = 32;
  localparam int TO = 8;
  localparam int LANES = W / M;

  logic         sm_clk = 1'b0;
  logic         reset;
  logic         start;
  logic [N-1:0] arguments;
  logic         finished;
  logic [M-1:0] received_data;
  logic         busy;
  logic [N-1:0] mem_address;
  logic         mem_read;
  logic         mem_waitrequest;
  logic [W-1:0] mem_readdata;
  logic         mem_readdatavalid;
  logic         timeout_error;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 sm_clk = ~sm_clk;

  flash_read_responder #(
    .N(N), .M(M), .W(W), .TIMEOUT_CYCLES(TO)
  ) dut (
    .sm_clk(sm_clk),
    .reset(reset),
    .start(start),
    .arguments(arguments),
    .finished(finished),
    .received_data(received_data),
    .busy(busy),
    .mem_address(mem_address),
    .mem_read(mem_read),
    .mem_waitrequest(mem_waitrequest),
    .mem_readdata(mem_readdata),
    .mem_readdatavalid(mem_readdatavalid),
    .timeout_error(timeout_error)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: element a lives in word a/LANES, lane a%LANES of that word.
  function automatic logic [M-1:0] ref_lane(input logic [N-1:0] a, input logic [W-1:0] word);
    int unsigned k;
    k = a % LANES;
    return word[k*M +: M];
  endfunction

  // One transaction: w stall cycles, data d cycles after acceptance, optional
  // extra start pulses while busy (one of them in DONE) that must be ignored.
  task automatic run_txn(input logic [N-1:0] addr, input int w, input int d,
                         input logic [W-1:0] word, input bit extra,
                         output logic [M-1:0] rd);
    int acc_c;
    int accepts;
    int fin_c;
    int fin_n;
    int exp_fin;
    acc_c   = -1;
    accepts = 0;
    fin_c   = -1;
    fin_n   = 0;
    rd      = '0;
    exp_fin = 3 + w + d;
    @(negedge sm_clk);
    start = 1'b1;
    arguments = addr;
    mem_readdatavalid = 1'b0;
    mem_waitrequest = 1'b0;
    for (int c = 1; c <= exp_fin + 2; c++) begin
      @(negedge sm_clk);
      start = extra && (c == 2 || c == exp_fin);
      arguments = $urandom;
      mem_waitrequest = (c <= w);
      mem_readdatavalid = 1'b0;
      mem_readdata = $urandom;
      if (acc_c >= 0 && c == acc_c + d) begin
        mem_readdatavalid = 1'b1;
        mem_readdata = word;
      end else if (!(acc_c >= 0 && c > acc_c && c < acc_c + d) && $urandom_range(0, 3) == 0) begin
        mem_readdatavalid = 1'b1;
      end
      check_val("busy", busy, c <= exp_fin);
      if (mem_read) begin
        check_val("mem_address", mem_address, addr / LANES);
        if (!mem_waitrequest) begin
          accepts++;
          acc_c = c;
        end
      end
      if (finished) begin
        fin_n++;
        fin_c = c;
        rd = received_data;
        check_val("rdata", received_data, ref_lane(addr, word));
        check_val("timeout_error", timeout_error, 0);
      end
    end
    start = 1'b0;
    mem_readdatavalid = 1'b0;
    check_val("accepts", accepts, 1);
    check_val("finished_count", fin_n, 1);
    check_val("finished_cycle", fin_c, exp_fin);
    check_val("rdata_hold", received_data, ref_lane(addr, word));
    $display("txn addr=0x%08h w=%0d d=%0d word=0x%08h extra=%0d -> rd=0x%02h fin_cycle=%0d",
             addr, w, d, word, extra, rd, fin_c);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [M-1:0] rd;
    int fin_seen;
    int fin_c;
    logic to_seen;
    logic [M-1:0] to_rd;

    reset = 1'b1;
    start = 1'b0;
    arguments = '0;
    mem_waitrequest = 1'b0;
    mem_readdata = '0;
    mem_readdatavalid = 1'b0;
    repeat (3) @(negedge sm_clk);
    check_val("reset_busy", busy, 0);
    check_val("reset_finished", finished, 0);
    check_val("reset_mem_read", mem_read, 0);
    check_val("reset_rdata", received_data, 0);
    check_val("reset_mem_address", mem_address, 0);
    check_val("reset_timeout_error", timeout_error, 0);
    reset = 1'b0;

    // Directed: element 6 -> word 1, lane 2 of 0xAABBCCDD.
    run_txn(32'h6, 0, 1, 32'hAABBCCDD, 1'b0, rd);
    check_val("directed_rdata", rd, 8'hBB);
    // Three stall cycles push completion out by three.
    run_txn(32'h6, 3, 1, 32'hAABBCCDD, 1'b0, rd);
    // Extra start pulses while busy.
    run_txn(32'h1234_5679, 0, 1, 32'h0102_0304, 1'b1, rd);
    // Back-to-back for two requesters: lane 3 then lane 0.
    run_txn(32'h3, 0, 1, 32'h11223344, 1'b0, rd);
    check_val("b2b_a", rd, 8'h11);
    run_txn(32'h4, 0, 1, 32'h55667788, 1'b0, rd);
    check_val("b2b_b", rd, 8'h88);

    for (int i = 0; i < 40; i++) begin
      run_txn($urandom, $urandom_range(0, 3), $urandom_range(1, 3), $urandom,
              1'($urandom_range(0, 1)), rd);
    end

    // Reset in WAIT_DATA followed by a late data beat.
    run_txn(32'h6, 0, 1, 32'hAABBCCDD, 1'b0, rd);
    @(negedge sm_clk);
    start = 1'b1;
    arguments = $urandom;
    mem_waitrequest = 1'b0;
    @(negedge sm_clk);
    start = 1'b0;
    @(negedge sm_clk);
    check_val("wd_busy", busy, 1);
    check_val("wd_mem_read", mem_read, 0);
    reset = 1'b1;
    @(negedge sm_clk);
    reset = 1'b0;
    mem_readdatavalid = 1'b1;
    mem_readdata = $urandom;
    fin_seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (finished) fin_seen++;
      @(negedge sm_clk);
      mem_readdatavalid = 1'b0;
    end
    check_val("abort_finished", fin_seen, 0);
    check_val("abort_busy", busy, 0);
    check_val("abort_rdata", received_data, 0);
    $display("txn reset-abort in WAIT_DATA: finished=%0d rd=0x%02h", fin_seen, received_data);

    // Reset and start in the same cycle.
    @(negedge sm_clk);
    reset = 1'b1;
    start = 1'b1;
    @(negedge sm_clk);
    reset = 1'b0;
    start = 1'b0;
    check_val("prio_busy", busy, 0);
    @(negedge sm_clk);
    check_val("prio_mem_read", mem_read, 0);
    $display("txn reset+start same cycle: busy=%0d", busy);

    // No data ever returned.
    @(negedge sm_clk);
    start = 1'b1;
    arguments = 32'h5;
    mem_waitrequest = 1'b0;
    fin_seen = 0;
    fin_c = -1;
    to_seen = 1'b0;
    to_rd = '1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge sm_clk);
      start = 1'b0;
      if (finished) begin
        fin_seen++;
        fin_c = c;
        to_seen = timeout_error;
        to_rd = received_data;
      end
    end
`ifdef RESP_TIMEOUT_EN
    check_val("to_finished_count", fin_seen, 1);
    check_val("to_finished_cycle", fin_c, TO + 1);
    check_val("to_error", to_seen, 1);
    check_val("to_rdata", to_rd, 0);
    check_val("to_busy_after", busy, 0);
`else
    check_val("hang_finished", fin_seen, 0);
    check_val("hang_busy", busy, 1);
`endif
    $display("txn no-data: finished=%0d cycle=%0d timeout_error=%0d busy=%0d",
             fin_seen, fin_c, to_seen, busy);
    reset = 1'b1;
    @(negedge sm_clk);
    reset = 1'b0;
    @(negedge sm_clk);
    check_val("final_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/flash_read_responder.md
FLASH_READ_RESPONDER -- requirements
Module: flash_read_responder

Interface
REQ-001 Parameter: N, 32, argument/address width.
REQ-002 Parameter: M, 8, returned data width; SHALL divide W.
REQ-003 Parameter: W, 32, memory read-data width.
REQ-004 Parameter: TIMEOUT_CYCLES, 255, cycle limit for timeout (used only with RESP_TIMEOUT_EN).
REQ-005 Port: sm_clk  input  1  single clock; all logic SHALL be on its rising edge.
REQ-006 Port: reset  input  1  synchronous, active-high reset.
REQ-007 Port: start  input  1  one-cycle request pulse from the shared-access arbiter.
REQ-008 Port: arguments  input  N  byte/element address of the requested datum.
REQ-009 Port: finished  output  1  one-cycle completion pulse to the arbiter.
REQ-010 Port: received_data  output  M  returned datum.
REQ-011 Port: busy  output  1  high in every state except IDLE.
REQ-012 Port: mem_address  output  N  word address = latched arguments >> log2(W/M).
REQ-013 Port: mem_read  output  1  read request to the memory slave.
REQ-014 Port: mem_waitrequest  input  1  slave stall; the request is accepted on a cycle with mem_read=1 and mem_waitrequest=0.
REQ-015 Port: mem_readdata  input  W  read word.
REQ-016 Port: mem_readdatavalid  input  1  mem_readdata valid this cycle.
REQ-017 Port: timeout_error  output  1  read abandoned; pulses together with finished.

Function
REQ-018 The FSM SHALL have states IDLE, ISSUE, WAIT_DATA, SELECT and DONE; outputs SHALL be decoded from the state register only.
REQ-019 IDLE: when start=1, SHALL latch arguments into an internal address register and go to ISSUE; otherwise stay.
REQ-020 ISSUE: mem_read=1 and mem_address driven from the latched register; stay while mem_waitrequest=1; go to WAIT_DATA when mem_waitrequest=0.
REQ-021 mem_readdatavalid SHALL be ignored in every state except WAIT_DATA.
REQ-022 WAIT_DATA: mem_read=0; on mem_readdatavalid=1, capture mem_readdata and go to SELECT.
REQ-023 SELECT: received_data SHALL be loaded with lane k of the captured word, bits [k*M+M-1 : k*M], where k = latched address mod (W/M); then go to DONE.
REQ-024 DONE: finished=1 for exactly one cycle, then go to IDLE.
REQ-025 received_data SHALL hold its value from SELECT until the next SELECT or reset.
REQ-026 Minimum latency, with no waitrequest and readdatavalid one cycle after acceptance: finished SHALL be high in the 4th cycle after the edge that samples start.
REQ-027 start while busy=1, including in DONE, SHALL be ignored and not queued.
REQ-028 Changes on arguments after the sampling edge SHALL not affect the read in progress.
REQ-029 The block SHALL drive mem_read for at most one request per transaction.

Reset
REQ-030 On reset=1 at a clock edge: state=IDLE; finished, mem_read, busy and timeout_error=0; received_data=0; mem_address=0.
REQ-031 Reset mid-transaction SHALL abort the transaction without asserting finished; any late mem_readdatavalid SHALL be ignored.
REQ-032 Reset SHALL take priority over start in the same cycle.

Configuration
REQ-033 With macro RESP_TIMEOUT_EN defined:
- a counter SHALL clear on leaving IDLE and increment each cycle in ISSUE or WAIT_DATA.
- when the count reaches TIMEOUT_CYCLES, the FSM SHALL go to DONE with mem_read=0, received_data=0, and timeout_error=1 in the same cycle as finished.
REQ-034 Without RESP_TIMEOUT_EN: no counter; timeout_error SHALL be tied to 0; ISSUE and WAIT_DATA SHALL wait indefinitely.

Verification
REQ-035 arguments=0x00000006, start pulse, readdata=0xAABBCCDD one cycle after acceptance -> mem_address=0x1, received_data=0xBB, finished in cycle 4.
REQ-036 mem_waitrequest held high 3 cycles -> mem_read stays high 4 cycles, mem_address stable, finished 3 cycles later than in REQ-035.
REQ-037 Second start pulse during WAIT_DATA -> ignored; exactly one finished pulse and one mem_read acceptance.
REQ-038 reset asserted in WAIT_DATA, then readdatavalid=1 next cycle -> no finished, state IDLE, received_data=0.
REQ-039 RESP_TIMEOUT_EN, TIMEOUT_CYCLES=8, readdatavalid never asserted -> finished and timeout_error high together, received_data=0x00; without the macro, busy stays 1.
REQ-040 Back-to-back transactions driven by the arbiter for requesters a and b, arguments 0x3 then 0x4 -> returns lane 3 then lane 0 of the respective words, one finished per start.
